// File: rtl/sme_match_collector_pkg.sv
// Shared types for the SME match collector: FSM states, the no-match marker
// and the per-packet descriptor layout.
package sme_collect_pkg;

  localparam int unsigned PKG_CNT_W = 5;

  localparam logic [31:0] NOMATCH_ID = 32'd0;

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    DISCARD
  } collect_state_t;

  typedef struct packed {
    logic                 overflow;
    logic [PKG_CNT_W-1:0] count;
  } match_desc_t;

endpackage

// File: rtl/sme_match_collector_fifo.sv
// First-word-fall-through synchronous FIFO with async reset and synchronous clear.
// Pointers carry an extra wrap bit so full and empty are told apart.
module sme_sync_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             valid,
  output logic             full
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             empty;
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign valid   = !empty;
  // Head reads as zero when empty so the outputs are quiet in and after reset.
  assign dout    = empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !clr) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/sme_match_collector.sv
// Groups SME rule-ID beats per packet into an ID FIFO and a descriptor FIFO.
// Optional counters: define SME_COLLECT_STATS_EN to implement stat_pkts/stat_dropped_ids.
module sme_match_collector
  import sme_collect_pkg::*;
#(
  parameter int unsigned ID_DEPTH   = 32,
  parameter int unsigned DESC_DEPTH = 4,
  parameter int unsigned MAX_RULES  = 16,
  parameter int unsigned CNT_W      = $clog2(MAX_RULES + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      match_rules_ID,
  input  logic             match_last,
  input  logic             match_valid,
  output logic             match_release,
  input  logic             flush,
  output logic [31:0]      out_rule_id,
  output logic             out_rule_valid,
  input  logic             out_rule_ready,
  output logic [CNT_W-1:0] out_desc_count,
  output logic             out_desc_overflow,
  output logic             out_desc_valid,
  input  logic             out_desc_ready,
  output logic [31:0]      stat_pkts,
  output logic [31:0]      stat_dropped_ids
);

  if (CNT_W > PKG_CNT_W) begin : g_cnt_w_check
    $error("CNT_W exceeds the descriptor count width of sme_collect_pkg");
  end

  collect_state_t   state, state_nx;
  logic [CNT_W-1:0] pkt_cnt, pkt_cnt_nx, cnt_after;
  logic             ovf, ovf_nx, ovf_after;
  logic             rel_q;
  logic             id_full, desc_full;
  logic             accept, is_id, in_pkt;
  logic             store, drop, desc_push;
  match_desc_t      desc_in;
  logic [CNT_W:0]   desc_dout;

  // Acceptance only looks at registered full flags; a same-cycle pop does not help.
  assign match_release = rel_q && !id_full && !desc_full && !flush;
  assign accept        = match_valid && match_release;
  assign is_id         = (match_rules_ID != NOMATCH_ID);
  assign in_pkt        = (state != DISCARD);
  assign store         = accept && in_pkt && is_id && (pkt_cnt < CNT_W'(MAX_RULES));
  assign drop          = accept && in_pkt && is_id && (pkt_cnt >= CNT_W'(MAX_RULES));
  assign cnt_after     = pkt_cnt + CNT_W'(store);
  assign ovf_after     = ovf | drop;

  assign desc_in.overflow = ovf_after;
  assign desc_in.count    = PKG_CNT_W'(cnt_after);

  always_comb begin
    state_nx   = state;
    pkt_cnt_nx = pkt_cnt;
    ovf_nx     = ovf;
    desc_push  = 1'b0;
    if (flush) begin
      pkt_cnt_nx = '0;
      ovf_nx     = 1'b0;
      if (state == COLLECT) state_nx = DISCARD;
    end else if (accept) begin
      case (state)
        DISCARD: if (match_last) state_nx = IDLE;
        default: begin
          if (match_last) begin
            desc_push  = 1'b1;
            pkt_cnt_nx = '0;
            ovf_nx     = 1'b0;
            state_nx   = IDLE;
          end else begin
            pkt_cnt_nx = cnt_after;
            ovf_nx     = ovf_after;
            state_nx   = COLLECT;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      pkt_cnt <= '0;
      ovf     <= 1'b0;
      rel_q   <= 1'b0;
    end else begin
      state   <= state_nx;
      pkt_cnt <= pkt_cnt_nx;
      ovf     <= ovf_nx;
      rel_q   <= 1'b1;
    end
  end

  sme_sync_fifo #(.WIDTH(32), .DEPTH(ID_DEPTH)) u_id_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (flush),
    .push  (store),
    .din   (match_rules_ID),
    .pop   (out_rule_ready),
    .dout  (out_rule_id),
    .valid (out_rule_valid),
    .full  (id_full)
  );

  sme_sync_fifo #(.WIDTH(CNT_W + 1), .DEPTH(DESC_DEPTH)) u_desc_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (flush),
    .push  (desc_push),
    .din   ({desc_in.overflow, desc_in.count[CNT_W-1:0]}),
    .pop   (out_desc_ready),
    .dout  (desc_dout),
    .valid (out_desc_valid),
    .full  (desc_full)
  );

  assign out_desc_overflow = desc_dout[CNT_W];
  assign out_desc_count    = desc_dout[CNT_W-1:0];

`ifdef SME_COLLECT_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_pkts        <= '0;
      stat_dropped_ids <= '0;
    end else begin
      if (desc_push && stat_pkts != '1)  stat_pkts        <= stat_pkts + 32'd1;
      if (drop && stat_dropped_ids != '1) stat_dropped_ids <= stat_dropped_ids + 32'd1;
    end
  end
`else
  assign stat_pkts        = '0;
  assign stat_dropped_ids = '0;
`endif

endmodule

// File: tb/tb_sme_match_collector.sv
// Bench for sme_match_collector: directed scenarios plus random traffic,
// checked every cycle against a queue-based packet model.
module tb_sme_match_collector;

  localparam int unsigned ID_DEPTH   = 32;
  localparam int unsigned DESC_DEPTH = 4;
  localparam int unsigned MAX_RULES  = 16;
  localparam int unsigned CNT_W      = 5;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [31:0]      match_rules_ID = '0;
  logic             match_last = 1'b0;
  logic             match_valid = 1'b0;
  logic             match_release;
  logic             flush = 1'b0;
  logic [31:0]      out_rule_id;
  logic             out_rule_valid;
  logic             out_rule_ready = 1'b0;
  logic [CNT_W-1:0] out_desc_count;
  logic             out_desc_overflow;
  logic             out_desc_valid;
  logic             out_desc_ready = 1'b0;
  logic [31:0]      stat_pkts;
  logic [31:0]      stat_dropped_ids;

  sme_match_collector #(
    .ID_DEPTH   (ID_DEPTH),
    .DESC_DEPTH (DESC_DEPTH),
    .MAX_RULES  (MAX_RULES),
    .CNT_W      (CNT_W)
  ) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .match_rules_ID    (match_rules_ID),
    .match_last        (match_last),
    .match_valid       (match_valid),
    .match_release     (match_release),
    .flush             (flush),
    .out_rule_id       (out_rule_id),
    .out_rule_valid    (out_rule_valid),
    .out_rule_ready    (out_rule_ready),
    .out_desc_count    (out_desc_count),
    .out_desc_overflow (out_desc_overflow),
    .out_desc_valid    (out_desc_valid),
    .out_desc_ready    (out_desc_ready),
    .stat_pkts         (stat_pkts),
    .stat_dropped_ids  (stat_dropped_ids)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned cnt;
    bit          ovf;
  } desc_t;

  // Packet-level model of what the core should see.
  int unsigned id_q[$];
  desc_t       desc_q[$];
  int unsigned cur_cnt;
  bit          cur_ovf;
  bit          open_pkt;
  bit          discarding;
  bit          rel_ok;
  int unsigned m_pkts;
  int unsigned m_dropped;
  bit          acc;
  bit          rnd_ready;

  int unsigned n_checks;
  int unsigned n_fail;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_clear_all();
    id_q.delete();
    desc_q.delete();
    cur_cnt = 0; cur_ovf = 0; open_pkt = 0; discarding = 0;
    rel_ok = 0; m_pkts = 0; m_dropped = 0;
  endtask

  function automatic logic [31:0] exp_stat(input int unsigned v);
`ifdef SME_COLLECT_STATS_EN
    return v;
`else
    return (v == 0) ? 32'd0 : 32'd0;
`endif
  endfunction

  // One clock: check at the falling edge, then advance the model to the next rising edge.
  task automatic step();
    bit exp_rel;
    if (rnd_ready) begin
      out_rule_ready = ($urandom_range(0, 3) != 0);
      out_desc_ready = ($urandom_range(0, 2) != 0);
    end
    @(negedge clk);
    exp_rel = rel_ok && (id_q.size() < ID_DEPTH) && (desc_q.size() < DESC_DEPTH) && !flush;
    check("release", match_release, exp_rel);
    check("rule_valid", out_rule_valid, id_q.size() > 0);
    if (id_q.size() > 0) check("rule_id", out_rule_id, id_q[0]);
    check("desc_valid", out_desc_valid, desc_q.size() > 0);
    if (desc_q.size() > 0) begin
      check("desc_count", out_desc_count, desc_q[0].cnt);
      check("desc_ovf", out_desc_overflow, desc_q[0].ovf);
    end
    check("stat_pkts", stat_pkts, exp_stat(m_pkts));
    check("stat_dropped", stat_dropped_ids, exp_stat(m_dropped));

    acc = 0;
    if (!rst_n) begin
      model_clear_all();
    end else begin
      if (out_rule_ready && id_q.size() > 0) void'(id_q.pop_front());
      if (out_desc_ready && desc_q.size() > 0) void'(desc_q.pop_front());
      if (flush) begin
        id_q.delete();
        desc_q.delete();
        cur_cnt = 0; cur_ovf = 0;
        if (open_pkt) begin open_pkt = 0; discarding = 1; end
      end else if (match_valid && exp_rel) begin
        acc = 1;
        if (discarding) begin
          if (match_last) discarding = 0;
        end else begin
          if (match_rules_ID != 0) begin
            if (cur_cnt < MAX_RULES) begin
              id_q.push_back(match_rules_ID);
              cur_cnt++;
            end else begin
              cur_ovf = 1;
              if (m_dropped != 32'hFFFF_FFFF) m_dropped++;
            end
          end
          if (match_last) begin
            desc_q.push_back('{cnt: cur_cnt, ovf: cur_ovf});
            cur_cnt = 0; cur_ovf = 0; open_pkt = 0;
            if (m_pkts != 32'hFFFF_FFFF) m_pkts++;
          end else begin
            open_pkt = 1;
          end
        end
      end
      rel_ok = 1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [31:0] id, input bit last);
    int unsigned n = 0;
    match_valid = 1; match_rules_ID = id; match_last = last;
    do begin step(); n++; end while (!acc && n < 200);
    check("beat_accepted", {31'd0, acc}, 32'd1);
    match_valid = 0;
  endtask

  task automatic do_flush();
    flush = 1;
    step();
    flush = 0;
  endtask

  task automatic idle(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) step();
  endtask

  initial begin
    n_checks = 0; n_fail = 0; rnd_ready = 0; acc = 0;
    model_clear_all();
    idle(3);
    rst_n = 1;
    idle(2);

    // Three IDs, core always ready.
    out_rule_ready = 1; out_desc_ready = 1;
    beat(32'h11, 0); beat(32'h22, 0); beat(32'h33, 1);
    idle(3);

    // Lone no-match marker closes an empty packet.
    beat(32'h0, 1);
    idle(2);

    // Twenty IDs: sixteen stored, four dropped.
    for (int unsigned i = 0; i < 20; i++) beat(32'h100 + i, (i == 19));
    idle(20);

    // Descriptor FIFO fills while the core stalls.
    out_rule_ready = 0; out_desc_ready = 0;
    for (int unsigned i = 0; i < 4; i++) beat(32'h200 + i, 1);
    match_valid = 1; match_rules_ID = 32'h204; match_last = 1;
    idle(3);
    out_desc_ready = 1;
    step();
    out_desc_ready = 0;
    beat(32'h204, 1);
    out_rule_ready = 1; out_desc_ready = 1;
    idle(12);

    // Flush mid-packet, remaining beats discarded.
    out_rule_ready = 0; out_desc_ready = 0;
    beat(32'h301, 0); beat(32'h302, 0);
    do_flush();
    beat(32'h303, 0); beat(32'h304, 1);
    beat(32'h305, 1);
    out_rule_ready = 1; out_desc_ready = 1;
    idle(4);

    // Asynchronous reset in the middle of a packet.
    beat(32'h401, 0); beat(32'h402, 0);
    #2 rst_n = 0;
    #1;
    model_clear_all();
    check("rst_release", match_release, 0);
    check("rst_rule_valid", out_rule_valid, 0);
    check("rst_rule_id", out_rule_id, 0);
    check("rst_desc_valid", out_desc_valid, 0);
    check("rst_desc_count", out_desc_count, 0);
    check("rst_desc_ovf", out_desc_overflow, 0);
    check("rst_stat_pkts", stat_pkts, 0);
    check("rst_stat_dropped", stat_dropped_ids, 0);
    idle(2);
    rst_n = 1;
    idle(1);
    beat(32'h501, 0); beat(32'h502, 1);
    idle(3);

    // Random traffic with random core back-pressure and occasional flushes.
    rnd_ready = 1;
    for (int unsigned i = 0; i < 700; i++) begin
      int unsigned r = $urandom_range(0, 49);
      if (r == 0) do_flush();
      else if (r < 8) step();
      else beat(($urandom_range(0, 4) == 0) ? 32'd0 : $urandom,
                ($urandom_range(0, 5) == 0));
    end
    rnd_ready = 0;
    out_rule_ready = 1; out_desc_ready = 1;
    idle(40);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
